// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the ALU decoder and iterative RV32M engine.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {LSA = 2'b00, BR = 2'b01, RT = 2'b10, IT = 2'b11} aluop_e;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_BNE  = 4'b1010;
  localparam logic [3:0] OP_BLT  = 4'b1011;
  localparam logic [3:0] OP_BGE  = 4'b1100;
  localparam logic [3:0] OP_BLTU = 4'b1101;
  localparam logic [3:0] OP_BGEU = 4'b1110;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MD   = 7'b0000001;

  function automatic logic md_is_div(md_op_e op);
    return op[2];
  endfunction

  function automatic logic md_sgn_a(md_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_sgn_b(md_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/alu_md_controller_if.sv
// EX-stage bundle between the pipeline and the ALU decoder / mul-div engine.
interface alu_md_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
);
  logic            valid_i;
  logic            flush_i;
  logic [1:0]      ALUOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic [OP_W-1:0] Operation;
  logic            illegal_o;
  logic            md_sel;
  logic [XLEN-1:0] md_result;
  logic            stall;

  modport master (
    output valid_i, flush_i, ALUOp, Funct7, Funct3, SrcA, SrcB,
    input  Operation, illegal_o, md_sel, md_result, stall
  );

  modport slave (
    input  valid_i, flush_i, ALUOp, Funct7, Funct3, SrcA, SrcB,
    output Operation, illegal_o, md_sel, md_result, stall
  );
endinterface

// File: rtl/md_iter_core.sv
// Iterative shift-add multiplier / restoring divider working on magnitudes.
// o_res_d is the signed-corrected result of the register values being written this cycle.
module md_iter_core
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  md_op_e          i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_special,
  output logic            o_last,
  output logic [XLEN-1:0] o_res_d
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [2*XLEN-1:0] r_acc, w_acc_d;
  logic [XLEN-1:0]   r_opb, w_opb_d;
  md_op_e            r_op, w_op_d;
  logic              r_neg, w_neg_d, r_neg_rem, w_neg_rem_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;

  logic              w_sa, w_sb, w_div_zero, w_ovf;
  logic [XLEN-1:0]   w_ma, w_mb, w_q, w_r;
  logic [2*XLEN:0]   w_t;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_p;

  assign w_sa       = md_sgn_a(i_op) & i_a[XLEN-1];
  assign w_sb       = md_sgn_b(i_op) & i_b[XLEN-1];
  assign w_ma       = w_sa ? -i_a : i_a;
  assign w_mb       = w_sb ? -i_b : i_b;
  assign w_div_zero = md_is_div(i_op) & (i_b == '0);
  assign w_ovf      = md_is_div(i_op) & md_sgn_a(i_op) & (&i_b) &
                      (i_a == {1'b1, {(XLEN-1){1'b0}}});
  assign o_special  = w_div_zero | w_ovf;
  assign o_last     = (r_cnt == CNT_W'(1));

  always_comb begin
    w_acc_d     = r_acc;
    w_opb_d     = r_opb;
    w_op_d      = r_op;
    w_neg_d     = r_neg;
    w_neg_rem_d = r_neg_rem;
    w_cnt_d     = r_cnt;
    w_t         = '0;
    w_diff      = '0;
    if (i_load) begin
      w_op_d      = i_op;
      w_neg_d     = w_sa ^ w_sb;
      w_neg_rem_d = w_sa;
      w_cnt_d     = CNT_W'(STEPS);
      if (md_is_div(i_op)) begin
        w_acc_d = {{XLEN{1'b0}}, w_ma};
        w_opb_d = w_mb;
      end else begin
        w_acc_d = {{XLEN{1'b0}}, w_mb};
        w_opb_d = w_ma;
      end
      // Special divides are preloaded so the normal fix-up yields the defined result.
      if (w_div_zero) begin
        w_acc_d = {w_ma, {XLEN{1'b1}}};
        w_neg_d = 1'b0;
        w_cnt_d = '0;
      end else if (w_ovf) begin
        w_neg_d = 1'b0;
        w_cnt_d = '0;
      end
    end else if (i_step) begin
      w_t = {1'b0, r_acc};
      for (int k = 0; k < UNROLL; k++) begin
        if (md_is_div(r_op)) begin
          w_t    = w_t << 1;
          w_diff = w_t[2*XLEN:XLEN] - {1'b0, r_opb};
          if (!w_diff[XLEN]) begin
            w_t[2*XLEN:XLEN] = w_diff;
            w_t[0]           = 1'b1;
          end
        end else begin
          if (w_t[0]) w_t[2*XLEN:XLEN] = {1'b0, w_t[2*XLEN-1:XLEN]} + {1'b0, r_opb};
          w_t = w_t >> 1;
        end
      end
      w_acc_d = w_t[2*XLEN-1:0];
      w_cnt_d = r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_p = w_neg_d ? -w_acc_d : w_acc_d;
    w_q = w_neg_d ? -w_acc_d[XLEN-1:0] : w_acc_d[XLEN-1:0];
    w_r = w_neg_rem_d ? -w_acc_d[2*XLEN-1:XLEN] : w_acc_d[2*XLEN-1:XLEN];
    case (w_op_d)
      MD_MUL:                       o_res_d = w_p[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: o_res_d = w_p[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              o_res_d = w_q;
      default:                      o_res_d = w_r;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_opb     <= '0;
      r_op      <= MD_MUL;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_acc     <= w_acc_d;
      r_opb     <= w_opb_d;
      r_op      <= w_op_d;
      r_neg     <= w_neg_d;
      r_neg_rem <= w_neg_rem_d;
      r_cnt     <= w_cnt_d;
    end
  end
endmodule

// File: rtl/alu_md_controller.sv
// ALU operation decoder plus the FSM that sequences the iterative mul/div core
// and stalls the front of the pipeline while it runs.
module alu_md_controller
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int OP_W   = 4
) (
  input logic clk,
  input logic reset,
  alu_md_if.slave bus
);
  md_state_e       r_state;
  logic            r_md_sel;
  logic [XLEN-1:0] r_md_result;

  logic [3:0]      w_op;
  logic            w_illegal, w_is_md, w_accept, w_step, w_special, w_last;
  logic [XLEN-1:0] w_res_d;

  always_comb begin
    w_op      = OP_ADD;
    w_illegal = 1'b0;
    case (aluop_e'(bus.ALUOp))
      LSA: w_op = OP_ADD;
      BR: begin
        case (bus.Funct3)
          3'b000:  w_op = OP_BEQ;
          3'b001:  w_op = OP_BNE;
          3'b100:  w_op = OP_BLT;
          3'b101:  w_op = OP_BGE;
          3'b110:  w_op = OP_BLTU;
          3'b111:  w_op = OP_BGEU;
          default: w_illegal = 1'b1;
        endcase
      end
      RT: begin
        if (bus.Funct7 == FUNCT7_MD) begin
          w_op = OP_ADD;
        end else if (bus.Funct7 == FUNCT7_BASE) begin
          case (bus.Funct3)
            3'b000:  w_op = OP_ADD;
            3'b001:  w_op = OP_SLL;
            3'b010:  w_op = OP_SLT;
            3'b011:  w_op = OP_SLTU;
            3'b100:  w_op = OP_XOR;
            3'b101:  w_op = OP_SRL;
            3'b110:  w_op = OP_OR;
            default: w_op = OP_AND;
          endcase
        end else if (bus.Funct7 == FUNCT7_ALT) begin
          case (bus.Funct3)
            3'b000:  w_op = OP_SUB;
            3'b101:  w_op = OP_SRA;
            default: w_illegal = 1'b1;
          endcase
        end else begin
          w_illegal = 1'b1;
        end
      end
      IT: begin
        case (bus.Funct3)
          3'b000: w_op = OP_ADD;
          3'b001: begin
            if (bus.Funct7 == FUNCT7_BASE) w_op = OP_SLL;
            else w_illegal = 1'b1;
          end
          3'b010: w_op = OP_SLT;
          3'b011: w_op = OP_SLTU;
          3'b100: w_op = OP_XOR;
          3'b101: begin
            if (bus.Funct7 == FUNCT7_BASE)     w_op = OP_SRL;
            else if (bus.Funct7 == FUNCT7_ALT) w_op = OP_SRA;
            else w_illegal = 1'b1;
          end
          3'b110:  w_op = OP_OR;
          default: w_op = OP_AND;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_is_md  = (bus.ALUOp == RT) && (bus.Funct7 == FUNCT7_MD);
  assign w_accept = (r_state == IDLE) && bus.valid_i && w_is_md && !bus.flush_i;
  assign w_step   = (r_state == BUSY) && !bus.flush_i;

  md_iter_core #(.XLEN(XLEN), .UNROLL(UNROLL)) u_core (
    .clk       (clk),
    .rst       (reset),
    .i_load    (w_accept),
    .i_step    (w_step),
    .i_op      (md_op_e'(bus.Funct3)),
    .i_a       (bus.SrcA),
    .i_b       (bus.SrcB),
    .o_special (w_special),
    .o_last    (w_last),
    .o_res_d   (w_res_d)
  );

  // DONE always falls back to IDLE so a still-valid instruction is not re-accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_md_sel    <= 1'b0;
      r_md_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_md_sel <= 1'b0;
          if (w_accept) begin
            if (w_special) begin
              r_state     <= DONE;
              r_md_sel    <= 1'b1;
              r_md_result <= w_res_d;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.flush_i) begin
            r_state <= IDLE;
          end else if (w_last) begin
            r_state     <= DONE;
            r_md_sel    <= 1'b1;
            r_md_result <= w_res_d;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_md_sel <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Operation = OP_W'(w_op);
  assign bus.illegal_o = w_illegal;
  assign bus.md_sel    = r_md_sel;
  assign bus.md_result = r_md_result;
  assign bus.stall     = w_accept || (r_state == BUSY);
endmodule

// File: tb/tb_alu_md_controller.sv
// Directed bench for alu_md_controller at UNROLL=1 and UNROLL=4; md results are
// checked through a per-instance scoreboard queue popped on each md_sel pulse.
module tb_alu_md_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        v = 1'b0;
  logic        fl = 1'b0;
  logic [1:0]  aluop = 2'b00;
  logic [6:0]  f7 = 7'b0;
  logic [2:0]  f3 = 3'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  alu_md_if #(.XLEN(32), .OP_W(4)) bus0 ();
  alu_md_if #(.XLEN(32), .OP_W(4)) bus1 ();

  assign bus0.valid_i = v & ~sel;
  assign bus1.valid_i = v & sel;
  assign bus0.flush_i = fl;
  assign bus1.flush_i = fl;
  assign bus0.ALUOp = aluop;
  assign bus1.ALUOp = aluop;
  assign bus0.Funct7 = f7;
  assign bus1.Funct7 = f7;
  assign bus0.Funct3 = f3;
  assign bus1.Funct3 = f3;
  assign bus0.SrcA = a;
  assign bus1.SrcA = a;
  assign bus0.SrcB = b;
  assign bus1.SrcB = b;

  alu_md_controller #(.XLEN(32), .UNROLL(1), .OP_W(4)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  alu_md_controller #(.XLEN(32), .UNROLL(4), .OP_W(4)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic        stall_w, mdsel_w;
  logic [31:0] mdres_w;
  assign stall_w = sel ? bus1.stall : bus0.stall;
  assign mdsel_w = sel ? bus1.md_sel : bus0.md_sel;
  assign mdres_w = sel ? bus1.md_result : bus0.md_result;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every md_sel pulse must match a queued expectation.
  always @(negedge clk) begin
    if (bus0.md_sel) begin
      chk("u1 md_sel has pending op", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) chk("u1 md_result", 64'(bus0.md_result), 64'(q0.pop_front()));
    end
    if (bus1.md_sel) begin
      chk("u4 md_sel has pending op", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) chk("u4 md_result", 64'(bus1.md_result), 64'(q1.pop_front()));
    end
  end

  task automatic dec(input logic [1:0] op, input logic [6:0] fu7, input logic [2:0] fu3,
                     input logic vi, input logic [3:0] exp_op, input logic exp_ill);
    @(negedge clk);
    aluop = op; f7 = fu7; f3 = fu3; v = vi;
    #1;
    chk("decode Operation", 64'(bus0.Operation), 64'(exp_op));
    chk("decode illegal_o", 64'(bus0.illegal_o), 64'(exp_ill));
    chk("decode stall", 64'(bus0.stall), 64'd0);
    v = 1'b0;
  endtask

  task automatic issue(input logic s, input logic [2:0] fu3, input logic [31:0] ai,
                       input logic [31:0] bi, input logic [31:0] exp, input int exp_stall);
    int n;
    @(negedge clk);
    sel = s; aluop = 2'b10; f7 = 7'b0000001; f3 = fu3; a = ai; b = bi; v = 1'b1;
    if (s) q1.push_back(exp); else q0.push_back(exp);
    n = 0;
    #1;
    while (stall_w && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    v = 1'b0;
    chk("stall cycles", 64'(n), 64'(exp_stall));
    @(negedge clk);
    #1;
    chk("md_sel one cycle", 64'(mdsel_w), 64'd0);
    chk("md_result held", 64'(mdres_w), 64'(exp));
  endtask

  task automatic run_set(input logic s, input int ns);
    issue(s, 3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, ns);
    issue(s, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ns);
    issue(s, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ns);
    issue(s, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ns);
    issue(s, 3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, ns);
    issue(s, 3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, ns);
    issue(s, 3'b101, 32'd100,      32'd7,        32'd14,        ns);
    issue(s, 3'b111, 32'd100,      32'd7,        32'd2,         ns);
    issue(s, 3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    issue(s, 3'b111, 32'd5,        32'd0,        32'd5,         1);
    issue(s, 3'b110, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 1);
    issue(s, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue(s, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset stall", 64'(bus0.stall), 64'd0);
    chk("reset md_sel", 64'(bus0.md_sel), 64'd0);
    chk("reset md_result", 64'(bus0.md_result), 64'd0);
    chk("reset md_result u4", 64'(bus1.md_result), 64'd0);
    reset = 1'b0;

    dec(2'b10, 7'b0100000, 3'b000, 1'b1, 4'b0100, 1'b0);
    dec(2'b01, 7'b0000000, 3'b110, 1'b1, 4'b1101, 1'b0);
    dec(2'b01, 7'b0000000, 3'b010, 1'b1, 4'b0010, 1'b1);
    dec(2'b01, 7'b0000000, 3'b101, 1'b1, 4'b1100, 1'b0);
    dec(2'b00, 7'b1111111, 3'b101, 1'b1, 4'b0010, 1'b0);
    dec(2'b10, 7'b0000000, 3'b011, 1'b1, 4'b1111, 1'b0);
    dec(2'b10, 7'b0100000, 3'b101, 1'b1, 4'b1001, 1'b0);
    dec(2'b10, 7'b0100000, 3'b001, 1'b1, 4'b0010, 1'b1);
    dec(2'b10, 7'b1111111, 3'b000, 1'b1, 4'b0010, 1'b1);
    dec(2'b10, 7'b0000001, 3'b100, 1'b0, 4'b0010, 1'b0);
    dec(2'b11, 7'b0000000, 3'b011, 1'b1, 4'b1111, 1'b0);
    dec(2'b11, 7'b0100000, 3'b101, 1'b1, 4'b1001, 1'b0);
    dec(2'b11, 7'b0000000, 3'b100, 1'b1, 4'b0011, 1'b0);
    dec(2'b11, 7'b0100000, 3'b001, 1'b1, 4'b0010, 1'b1);

    run_set(1'b0, 33);
    run_set(1'b1, 9);

    // M-op presented together with flush in IDLE must not be accepted.
    @(negedge clk);
    sel = 1'b0; aluop = 2'b10; f7 = 7'b0000001; f3 = 3'b000; a = 32'd3; b = 32'd4;
    v = 1'b1; fl = 1'b1;
    #1 chk("flush idle no stall", 64'(stall_w), 64'd0);
    @(negedge clk);
    v = 1'b0; fl = 1'b0;
    #1 chk("flush idle not busy", 64'(stall_w), 64'd0);

    // Flush at BUSY cycle 10.
    @(negedge clk);
    sel = 1'b0; f3 = 3'b100; a = 32'd100; b = 32'd3; v = 1'b1;
    #1 chk("flush accept stall", 64'(stall_w), 64'd1);
    repeat (10) @(negedge clk);
    fl = 1'b1;
    #1 chk("flush busy stall", 64'(stall_w), 64'd1);
    @(negedge clk);
    fl = 1'b0; v = 1'b0;
    #1 chk("flush stall drop", 64'(stall_w), 64'd0);
    chk("flush md_sel", 64'(mdsel_w), 64'd0);
    repeat (40) @(negedge clk);
    #1 chk("flush no result", 64'(mdsel_w), 64'd0);

    // Reset at BUSY cycle 5.
    @(negedge clk);
    sel = 1'b0; f3 = 3'b000; a = 32'd9; b = 32'd9; v = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1; v = 1'b0;
    #1;
    chk("reset busy stall", 64'(bus0.stall), 64'd0);
    chk("reset busy md_sel", 64'(bus0.md_sel), 64'd0);
    chk("reset busy md_result", 64'(bus0.md_result), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 3'b000, 32'd12345, 32'd678, 32'd8369910, 33);
    issue(1'b1, 3'b000, 32'd12345, 32'd678, 32'd8369910, 9);

    repeat (3) @(negedge clk);
    chk("scoreboard drained u1", 64'(q0.size()), 64'd0);
    chk("scoreboard drained u4", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
